// File: rtl/lcd_command_sequencer.sv
// Character-LCD command sequencer: 4-bit power-on init, configuration
// list, host character/clear issue, cursor wrap and clk_cnt timebase.
module lcd_command_sequencer #(
    parameter int T_POWERUP = 750000,
    parameter int T_INIT_1  = 205000,
    parameter int T_INIT_2  = 5000,
    parameter int T_INIT_3  = 2000,
    parameter int T_E_PULSE = 12,
    parameter int T_CLEAR   = 82000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_enable,
    input  logic        instr_done,
    output logic        next_instruction,
    output logic [9:0]  instr_db,
    output logic [11:0] clk_cnt,
    output logic        init_active,
    output logic [3:0]  init_sf_d,
    output logic        init_lcd_e,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        clear_req,
    output logic        ready
);

    typedef enum logic [3:0] {
        S_PWR_WAIT,
        S_NIB_SETUP,
        S_NIB_PULSE,
        S_NIB_HOLD,
        S_INIT_WAIT,
        S_CFG_ISSUE,
        S_WAIT_DONE,
        S_CLEAR_WAIT,
        S_READY
    } state_t;

    // What the outstanding instruction was, so its completion is routed
    typedef enum logic [2:0] {
        K_CFG,
        K_CHAR,
        K_CURSOR,
        K_CLEAR,
        K_HOME
    } kind_t;

    localparam logic [19:0] L_PWR   = 20'(T_POWERUP - 1);
    localparam logic [19:0] L_INIT1 = 20'(T_INIT_1 - 1);
    localparam logic [19:0] L_INIT2 = 20'(T_INIT_2 - 1);
    localparam logic [19:0] L_INIT3 = 20'(T_INIT_3 - 1);
    localparam logic [19:0] L_E     = 20'(T_E_PULSE - 1);
    localparam logic [19:0] L_CLR   = 20'(T_CLEAR - 1);

    state_t      r_state;
    kind_t       r_kind;
    logic [19:0] r_cnt;
    logic [1:0]  r_nib_idx;
    logic [2:0]  r_cfg_idx;
    logic [5:0]  r_cursor;
    logic        r_clear_pending;
    logic        r_next;
    logic [9:0]  r_db;
    logic [11:0] r_clk_cnt;
    logic        r_init_active;
    logic [3:0]  r_sf_d;
    logic        r_lcd_e;
    logic        r_char_ready;
    logic        r_ready;

    logic [19:0] w_wait_last;
    logic [3:0]  w_nib_next;
    logic [5:0]  w_cur_inc;
    logic        w_go_clear;
    logic        w_to_ready;

    function automatic logic [7:0] cfg_byte(input logic [2:0] idx);
        unique case (idx)
            3'd0:    cfg_byte = 8'h28;
            3'd1:    cfg_byte = 8'h06;
            3'd2:    cfg_byte = 8'h0C;
            3'd3:    cfg_byte = 8'h01;
            default: cfg_byte = 8'h80;
        endcase
    endfunction

    assign w_nib_next = (r_nib_idx == 2'd2) ? 4'h2 : 4'h3;
    assign w_cur_inc  = r_cursor + 6'd1;
    assign w_go_clear = r_clear_pending | (clear_req & r_ready);

    // Wait length following the current init nibble
    always_comb begin
        unique case (r_nib_idx)
            2'd0:    w_wait_last = L_INIT1;
            2'd1:    w_wait_last = L_INIT2;
            default: w_wait_last = L_INIT3;
        endcase
    end

    // A completed instruction that hands control back to the host side
    always_comb begin
        w_to_ready = 1'b0;
        if (r_state == S_WAIT_DONE && instr_done) begin
            unique case (r_kind)
                K_CHAR:
                    w_to_ready = (w_cur_inc != 6'd16) &&
                                 (w_cur_inc != 6'd32);
                K_CURSOR, K_HOME:
                    w_to_ready = 1'b1;
                default:
                    w_to_ready = 1'b0;
            endcase
        end
    end

    // Timebase for the instruction FSM: clears when idle, saturates at max
    always_ff @(posedge clk) begin
        if (reset || !instr_enable) begin
            r_clk_cnt <= 12'd0;
        end else if (r_clk_cnt != 12'hFFF) begin
            r_clk_cnt <= r_clk_cnt + 12'd1;
        end
    end

    // Init, configuration and host sequencing with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_PWR_WAIT;
            r_kind          <= K_CFG;
            r_cnt           <= 20'd0;
            r_nib_idx       <= 2'd0;
            r_cfg_idx       <= 3'd0;
            r_cursor        <= 6'd0;
            r_clear_pending <= 1'b0;
            r_next          <= 1'b0;
            r_db            <= 10'd0;
            r_init_active   <= 1'b1;
            r_sf_d          <= 4'h0;
            r_lcd_e         <= 1'b0;
            r_char_ready    <= 1'b0;
            r_ready         <= 1'b0;
        end else begin
            r_next <= 1'b0;
            if (r_ready && r_state != S_READY && clear_req) begin
                r_clear_pending <= 1'b1;
            end
            unique case (r_state)
                S_PWR_WAIT: begin
                    if (r_cnt == L_PWR) begin
                        r_cnt   <= 20'd0;
                        r_sf_d  <= 4'h3;
                        r_state <= S_NIB_SETUP;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                S_NIB_SETUP: begin
                    r_lcd_e <= 1'b1;
                    r_cnt   <= 20'd0;
                    r_state <= S_NIB_PULSE;
                end
                S_NIB_PULSE: begin
                    if (r_cnt == L_E) begin
                        r_lcd_e <= 1'b0;
                        r_state <= S_NIB_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                S_NIB_HOLD: begin
                    r_sf_d  <= 4'h0;
                    r_cnt   <= 20'd0;
                    r_state <= S_INIT_WAIT;
                end
                S_INIT_WAIT: begin
                    if (r_cnt == w_wait_last) begin
                        r_cnt <= 20'd0;
                        if (r_nib_idx == 2'd3) begin
                            r_init_active <= 1'b0;
                            r_state       <= S_CFG_ISSUE;
                        end else begin
                            r_nib_idx <= r_nib_idx + 2'd1;
                            r_sf_d    <= w_nib_next;
                            r_state   <= S_NIB_SETUP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                S_CFG_ISSUE: begin
                    r_db    <= {2'b00, cfg_byte(r_cfg_idx)};
                    r_next  <= 1'b1;
                    r_kind  <= K_CFG;
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (instr_done) begin
                        unique case (r_kind)
                            K_CFG: begin
                                if (r_db[7:0] == 8'h01) begin
                                    r_cnt   <= 20'd0;
                                    r_state <= S_CLEAR_WAIT;
                                end else if (r_cfg_idx == 3'd4) begin
                                    r_cursor     <= 6'd0;
                                    r_ready      <= 1'b1;
                                    r_char_ready <= 1'b1;
                                    r_state      <= S_READY;
                                end else begin
                                    r_cfg_idx <= r_cfg_idx + 3'd1;
                                    r_db   <= {2'b00, cfg_byte(r_cfg_idx + 3'd1)};
                                    r_next <= 1'b1;
                                end
                            end
                            K_CHAR: begin
                                if (w_cur_inc == 6'd16) begin
                                    r_cursor <= 6'd16;
                                    r_db     <= 10'h0C0;
                                    r_next   <= 1'b1;
                                    r_kind   <= K_CURSOR;
                                end else if (w_cur_inc == 6'd32) begin
                                    r_cursor <= 6'd0;
                                    r_db     <= 10'h080;
                                    r_next   <= 1'b1;
                                    r_kind   <= K_CURSOR;
                                end else begin
                                    r_cursor <= w_cur_inc;
                                end
                            end
                            K_CLEAR: begin
                                r_cnt   <= 20'd0;
                                r_state <= S_CLEAR_WAIT;
                            end
                            K_HOME: begin
                                r_cursor <= 6'd0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_CLEAR_WAIT: begin
                    if (r_cnt == L_CLR) begin
                        r_cnt   <= 20'd0;
                        r_next  <= 1'b1;
                        r_state <= S_WAIT_DONE;
                        if (r_kind == K_CFG) begin
                            r_cfg_idx <= r_cfg_idx + 3'd1;
                            r_db <= {2'b00, cfg_byte(r_cfg_idx + 3'd1)};
                        end else begin
                            r_db   <= 10'h080;
                            r_kind <= K_HOME;
                        end
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                S_READY: begin
                    if (w_go_clear) begin
                        r_char_ready    <= 1'b0;
                        r_clear_pending <= 1'b0;
                        r_db            <= 10'h001;
                        r_next          <= 1'b1;
                        r_kind          <= K_CLEAR;
                        r_state         <= S_WAIT_DONE;
                    end else if (char_valid && r_char_ready) begin
                        r_char_ready <= 1'b0;
                        r_db         <= {2'b10, char_data};
                        r_next       <= 1'b1;
                        r_kind       <= K_CHAR;
                        r_state      <= S_WAIT_DONE;
                    end
                end
                default: begin
                    r_state <= S_PWR_WAIT;
                end
            endcase
            // A pending clear is serviced before the host gets char_ready
            if (w_to_ready) begin
                if (w_go_clear) begin
                    r_clear_pending <= 1'b0;
                    r_db            <= 10'h001;
                    r_next          <= 1'b1;
                    r_kind          <= K_CLEAR;
                    r_state         <= S_WAIT_DONE;
                end else begin
                    r_char_ready <= 1'b1;
                    r_state      <= S_READY;
                end
            end
        end
    end

    assign next_instruction = r_next;
    assign instr_db         = r_db;
    assign clk_cnt          = r_clk_cnt;
    assign init_active      = r_init_active;
    assign init_sf_d        = r_sf_d;
    assign init_lcd_e       = r_lcd_e;
    assign char_ready       = r_char_ready;
    assign ready            = r_ready;

endmodule

// File: tb/tb_lcd_command_sequencer.sv
// Randomized bench for lcd_command_sequencer against an issue-list model
// and a modelled instruction FSM.
module tb_lcd_command_sequencer;

    localparam int TPU = 20;
    localparam int TI1 = 10;
    localparam int TI2 = 5;
    localparam int TI3 = 3;
    localparam int TE  = 4;
    localparam int TCL = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_enable = 1'b0;
    logic        instr_done = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        clear_req = 1'b0;
    logic        next_instruction;
    logic [9:0]  instr_db;
    logic [11:0] clk_cnt;
    logic        init_active;
    logic [3:0]  init_sf_d;
    logic        init_lcd_e;
    logic        char_ready;
    logic        ready;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int lat = 20;
    int busy_cnt = 0;
    logic busy = 1'b0;
    logic inject_req = 1'b0;
    logic [9:0] held = 10'd0;

    logic [9:0] issued_q[$];
    int         pcyc_q[$];
    int         dcyc_q[$];
    logic [9:0] exp_q[$];
    int cursor_m = 0;
    int cmp_idx = 0;
    int cfg_base = 0;
    logic [9:0] cfg_l[5] = '{10'h028, 10'h006, 10'h00C, 10'h001, 10'h080};

    lcd_command_sequencer #(
        .T_POWERUP(TPU), .T_INIT_1(TI1), .T_INIT_2(TI2),
        .T_INIT_3(TI3), .T_E_PULSE(TE), .T_CLEAR(TCL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .instr_enable(instr_enable),
        .instr_done(instr_done),
        .next_instruction(next_instruction),
        .instr_db(instr_db),
        .clk_cnt(clk_cnt),
        .init_active(init_active),
        .init_sf_d(init_sf_d),
        .init_lcd_e(init_lcd_e),
        .char_valid(char_valid),
        .char_data(char_data),
        .char_ready(char_ready),
        .clear_req(clear_req),
        .ready(ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: the instruction words the LCD should receive, in order
    function automatic void m_cfg();
        for (int i = 0; i < 5; i++) exp_q.push_back(cfg_l[i]);
        cursor_m = 0;
    endfunction

    function automatic void m_char(input logic [7:0] c);
        exp_q.push_back({2'b10, c});
        cursor_m++;
        if (cursor_m == 16) exp_q.push_back(10'h0C0);
        else if (cursor_m == 32) begin
            exp_q.push_back(10'h080);
            cursor_m = 0;
        end
    endfunction

    function automatic void m_clear();
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h080);
        cursor_m = 0;
    endfunction

    // Instruction FSM model: done 'lat' cycles after each start pulse
    initial begin
        forever begin
            @(negedge clk);
            instr_done = 1'b0;
            if (reset) begin
                if (busy) dcyc_q.push_back(-1);
                busy = 1'b0;
                instr_enable = 1'b0;
            end else if (busy) begin
                busy_cnt++;
                chk("nxt_reissue", next_instruction, 0);
                chk("db_hold", instr_db, held);
                chk("crdy_busy", char_ready, 0);
                chk("clk_cnt", clk_cnt, (busy_cnt > 4095) ? 4095 : busy_cnt);
                if (busy_cnt >= lat) begin
                    instr_done = 1'b1;
                    instr_enable = 1'b0;
                    busy = 1'b0;
                    dcyc_q.push_back(cyc);
                end
            end else begin
                chk("clk_cnt_idle", clk_cnt, 0);
                if (next_instruction) begin
                    issued_q.push_back(instr_db);
                    pcyc_q.push_back(cyc);
                    held = instr_db;
                    busy = 1'b1;
                    busy_cnt = 0;
                    instr_enable = 1'b1;
                end else if (inject_req) begin
                    instr_done = 1'b1;
                    inject_req = 1'b0;
                end
            end
        end
    end

    task automatic compare_issued();
        chk("issue_count", issued_q.size(), exp_q.size());
        while (cmp_idx < issued_q.size() && cmp_idx < exp_q.size()) begin
            chk($sformatf("issue[%0d]", cmp_idx), issued_q[cmp_idx], exp_q[cmp_idx]);
            cmp_idx++;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(char_ready && !busy && issued_q.size() >= exp_q.size()) && k < 6000) begin
            @(negedge clk);
            k++;
        end
        chk("wait_idle", k < 6000, 1);
    endtask

    task automatic wait_crdy();
        int k = 0;
        while (!char_ready && k < 6000) begin
            @(negedge clk);
            k++;
        end
        chk("crdy_wait", k < 6000, 1);
    endtask

    task automatic send_char(input logic [7:0] c);
        wait_crdy();
        m_char(c);
        char_data = c;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        chk("crdy_after_accept", char_ready, 0);
    endtask

    task automatic do_clear(input logic with_char);
        wait_crdy();
        m_clear();
        clear_req = 1'b1;
        if (with_char) begin
            char_valid = 1'b1;
            char_data = 8'($urandom_range(65, 90));
        end
        @(negedge clk);
        clear_req = 1'b0;
        char_valid = 1'b0;
        chk("crdy_after_clear", char_ready, 0);
    endtask

    // Reset, then compare init pins cycle by cycle against the phase list
    task automatic reset_and_init();
        logic [5:0] e[$];
        logic [3:0] nib;
        int w;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_active", init_active, 1);
        chk("rst_ready", ready, 0);
        chk("rst_crdy", char_ready, 0);
        chk("rst_next", next_instruction, 0);
        chk("rst_db", instr_db, 0);
        chk("rst_clkcnt", clk_cnt, 0);
        chk("rst_sfd_e", {init_sf_d, init_lcd_e}, 0);
        @(negedge clk);
        cfg_base = issued_q.size();
        for (int i = 0; i < TPU; i++) e.push_back(6'b10_0000);
        for (int n = 0; n < 4; n++) begin
            nib = (n == 3) ? 4'h2 : 4'h3;
            w = (n == 0) ? TI1 : (n == 1) ? TI2 : TI3;
            e.push_back({2'b10, nib});
            for (int j = 0; j < TE; j++) e.push_back({2'b11, nib});
            e.push_back({2'b10, nib});
            for (int j = 0; j < w; j++) e.push_back(6'b10_0000);
        end
        e.push_back(6'b00_0000);
        for (int i = 0; i < e.size(); i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("init[%0d]", i), {init_active, init_lcd_e, init_sf_d}, e[i]);
            if (i == 0) reset = 1'b0;
        end
        m_cfg();
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("ready_timeout", k < 3000, 1);
        chk("ready_crdy", char_ready, 1);
        chk("ready_lat", cyc - dcyc_q[cfg_base + 4], 1);
        for (int j = 1; j < 5; j++)
            chk($sformatf("cfg_gap%0d", j),
                pcyc_q[cfg_base + j] - dcyc_q[cfg_base + j - 1], (j == 4) ? 9 : 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int ci;
        int k;
        reset_and_init();
        wait_ready();
        compare_issued();

        send_char(8'h41);
        wait_idle();
        compare_issued();

        for (int i = 0; i < 47; i++) send_char(8'($urandom_range(32, 126)));
        wait_idle();
        compare_issued();

        do_clear(1'b1);
        wait_idle();
        compare_issued();

        send_char(8'h5A);
        repeat (3) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        m_clear();
        wait_idle();
        compare_issued();
        ci = exp_q.size() - 2;
        chk("clr_after_write", pcyc_q[ci] - dcyc_q[ci - 1], 1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) do_clear(1'($urandom_range(0, 1)));
            else send_char(8'($urandom_range(32, 126)));
        end
        wait_idle();
        compare_issued();

        k = issued_q.size();
        inject_req = 1'b1;
        repeat (6) @(negedge clk);
        chk("spurious_done_issue", issued_q.size(), k);
        chk("spurious_done_crdy", char_ready, 1);

        lat = 4100;
        send_char(8'h7E);
        wait_idle();
        lat = 20;
        compare_issued();

        wait_crdy();
        exp_q.push_back(10'h001);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        k = 0;
        while (!(issued_q.size() == exp_q.size() && dcyc_q.size() == issued_q.size())
               && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("clr_done_wait", k < 500, 1);
        repeat (3) @(negedge clk);
        reset_and_init();
        repeat (10) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        wait_ready();
        chk("ready_hold", ready, 1);
        for (int i = 0; i < 5; i++) send_char(8'($urandom_range(32, 126)));
        wait_idle();
        compare_issued();
        chk("ready_end", ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_command_sequencer.md
Name: lcd_command_sequencer

Overview:
- Top-level sequencer for the character-LCD path. It runs the 4-bit power-on init by driving the LCD nibble and enable directly.
- It then issues the configuration command list and accepts characters from a host one at a time. Each command and character goes to the instruction FSM as a 10-bit {RS,RW,byte} word.
- It owns the 12-bit clk_cnt timebase the instruction FSM consumes. It also owns DDRAM cursor wrap between the two 16-char lines.

Parameters:
- T_POWERUP, 750000, cycles waited after reset before the first init nibble (15 ms @ 50 MHz).
- T_INIT_1, 205000, wait after nibble 1 (4.1 ms).
- T_INIT_2, 5000, wait after nibble 2 (100 us).
- T_INIT_3, 2000, wait after nibbles 3 and 4 (40 us).
- T_E_PULSE, 12, init_lcd_e high time in cycles.
- T_CLEAR, 82000, extra wait after a Clear Display (0x01) completes (1.64 ms).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- instr_enable  in  1  instruction FSM busy flag; clk_cnt counts while high.
- instr_done  in  1  one-cycle pulse from the instruction FSM at instruction completion.
- next_instruction  out  1  one-cycle start pulse to the instruction FSM.
- instr_db  out  10  [9]=RS, [8]=RW, [7:0]=command/char byte.
- clk_cnt  out  12  timebase for the instruction FSM.
- init_active  out  1  high during power-on init; the top-level mux selects init_sf_d/init_lcd_e onto SF_D[11:8]/LCD_E.
- init_sf_d  out  4  init nibble.
- init_lcd_e  out  1  init enable strobe.
- char_valid  in  1  host character request.
- char_data  in  8  ASCII code; sampled on accept.
- char_ready  out  1  high when a character can be accepted.
- clear_req  in  1  host clear-screen request; level or pulse.
- ready  out  1  high when init and configuration are complete.

Behaviour:
- Reset state: all outputs registered. Reset values: next_instruction=0, instr_db=0, clk_cnt=0, init_active=1, init_sf_d=0, init_lcd_e=0, char_ready=0, ready=0. FSM enters PWR_WAIT; delay counter=0, cursor=0, clear_pending=0.
- Reset mid-operation: asserting reset in any state restarts the full init from PWR_WAIT on the next cycle.
- clk_cnt rules:
  - cleared to 0 on any cycle instr_enable=0;
  - otherwise increments by 1;
  - saturates at 4095 (no wrap).
- Init (init_active=1): the following phases run in order.
  - PWR_WAIT: T_POWERUP cycles.
  - NIB: one nibble pulse. It has three sub-phases:
    - init_sf_d set one cycle before init_lcd_e rises;
    - init_lcd_e high for exactly T_E_PULSE cycles;
    - init_sf_d held one cycle after init_lcd_e falls, then returns to 0.
  - Nibble/wait sequence: 0x3, wait T_INIT_1; 0x3, wait T_INIT_2; 0x3, wait T_INIT_3; 0x2, wait T_INIT_3.
  - Then init_active drops to 0 and the FSM enters CFG_ISSUE.
  - Delay counter: 20-bit; the wait length is compared as count==T-1.
- Command issue (ISSUE/WAIT_DONE):
  - instr_db is loaded, and next_instruction pulses high for exactly 1 cycle in the same cycle.
  - instr_db then holds stable until instr_done is seen.
  - next_instruction is not re-pulsed while waiting.
  - An instr_done arriving with no outstanding issue is ignored.
- Configuration list, all RS=0, RW=0, issued in order: 0x28, 0x06, 0x0C, 0x01, 0x80.
  - After the 0x01 done, the FSM waits T_CLEAR cycles (CLEAR_WAIT) before the next issue.
  - After the 0x80 done: cursor=0, ready=1, enter READY.
- READY:
  - char_ready=1.
  - Accept happens when char_valid&char_ready. On accept, char_ready=0 from the next cycle and instr_db={1,0,char_data} is issued.
  - After instr_done, cursor increments. cursor==16 issues 0xC0. cursor==32 sets cursor=0 and issues 0x80. The FSM then returns to READY.
- Clear handling:
  - In READY, clear_req takes priority over char_valid in the same cycle (the char is not accepted).
  - The FSM issues 0x01, waits T_CLEAR, issues 0x80, then sets cursor=0.
  - clear_req seen while not in READY (after ready=1) sets clear_pending. It is serviced on the next READY entry, before any char, then cleared.
  - clear_req before ready=1 is ignored.
- ready stays 1 once set, until reset. char_ready is 0 in every state except READY.

Test Plan:
- Bench parameters: T_POWERUP=20, T_INIT_1=10, T_INIT_2=5, T_INIT_3=3, T_E_PULSE=4, T_CLEAR=8.
- Reset, then run init -> init_lcd_e pulses 4 times, each 4 cycles wide, with nibbles 3,3,3,2. Gaps between falling and rising edges are 10/5/3 cycles (plus setup/hold). init_active falls after the final 3-cycle wait.
- Config with a modelled instruction FSM returning done 20 cycles after start -> instr_db sequence 0x028, 0x006, 0x00C, 0x001, 0x080. Exactly one next_instruction pulse per command. 8 idle cycles after the 0x001 done. ready=1 after the 0x080 done.
- Write 'A' (0x41) -> instr_db=0x141. char_ready low until done, then high. clk_cnt counts 0,1,2… while instr_enable=1 and reads 0 when low.
- Write 16 chars, then 16 more -> 0x0C0 issued after char 16, 0x080 after char 32, cursor back to 0.
- clear_req and char_valid asserted together in READY -> 0x001 issued, char not accepted, then 0x080. clear_req pulsed during a char write -> clear serviced immediately after that write completes.
- reset asserted during CLEAR_WAIT -> next cycle init_active=1, ready=0, and the full init sequence repeats.
